// File: rtl/lvds_word_align_ctrl.sv
// lvds_word_align_ctrl
//   Word-alignment controller for the clock lane of one LVDS channel. It
//   issues single-cycle bitslip pulses to the 7:1 deserializer until the
//   clock-lane word equals ALIGN_PATTERN, declares lock after LOCK_COUNT
//   consecutive good words, and drops lock after LOSS_THRESH consecutive
//   bad words or on an I_realign request.
//
// Ports
//   I_clk                pixel-rate clock (deserializer parallel clock)
//   I_rst                synchronous active-high reset
//   I_phase_align_pdata  aligned P-lane word from the comparison stage
//   I_lane_match         P equals inverted N for this word
//   I_realign            single-cycle request to drop lock and re-search
//   O_bitslip            single-cycle bitslip pulse to the deserializer
//   O_locked             word lock achieved
//   O_lock_lost          single-cycle pulse on LOCKED -> SEARCH
//   O_align_err          sticky, a full 7-slip rotation completed without lock
//   O_word_data          registered aligned word
//   O_word_valid         O_word_data is valid (locked and word good)
//   O_dbg_state          current FSM state, for debug and checker binding
//   O_slip_total         saturating bitslip count (LVDS_ALIGN_SLIP_STATS_EN only)
//
// Optional feature macro: LVDS_ALIGN_SLIP_STATS_EN adds O_slip_total.
//
// Output handshake: O_word_valid qualifies O_word_data in the same cycle.
// There is no ready input; the downstream unpacker must accept every word
// presented with O_word_valid=1 (no backpressure).
module lvds_word_align_ctrl #(
  parameter logic [6:0]  ALIGN_PATTERN = 7'b1100011,
  parameter int unsigned SLIP_WAIT     = 15,
  parameter int unsigned LOCK_COUNT    = 64,
  parameter int unsigned LOSS_THRESH   = 4
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic [6:0] I_phase_align_pdata,
  input  logic       I_lane_match,
  input  logic       I_realign,
  output logic       O_bitslip,
  output logic       O_locked,
  output logic       O_lock_lost,
  output logic       O_align_err,
  output logic [6:0] O_word_data,
  output logic       O_word_valid,
  output logic [2:0] O_dbg_state
`ifdef LVDS_ALIGN_SLIP_STATS_EN
  ,
  output logic [7:0] O_slip_total
`endif
);

  typedef enum logic [2:0] {
    ST_SEARCH = 3'd0,
    ST_SLIP   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_VERIFY = 3'd3,
    ST_LOCKED = 3'd4
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(SLIP_WAIT - 1);
  localparam logic [9:0] LOCK_CNT  = 10'(LOCK_COUNT);
  localparam logic [3:0] LOSS_CNT  = 4'(LOSS_THRESH);

  state_e     state_q, state_d;
  logic [2:0] slip_cnt_q, slip_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [9:0] good_cnt_q, good_cnt_d;
  logic [3:0] miss_cnt_q, miss_cnt_d;
  logic       bitslip_q, bitslip_d;
  logic       locked_q, locked_d;
  logic       lock_lost_q, lock_lost_d;
  logic       align_err_q, align_err_d;
  logic [6:0] word_data_q, word_data_d;
  logic       word_valid_q, word_valid_d;
  logic       good_word;
  logic       realign_take;

  assign good_word    = I_lane_match && (I_phase_align_pdata == ALIGN_PATTERN);
  // A realign during SLIP/WAIT is dropped: a search is already under way.
  assign realign_take = I_realign && (state_q != ST_SLIP) && (state_q != ST_WAIT);

  always_comb begin
    state_d     = state_q;
    slip_cnt_d  = slip_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    good_cnt_d  = good_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    align_err_d = align_err_q;
    lock_lost_d = 1'b0;

    if (realign_take) begin
      // Realign outranks a simultaneous lock or loss-of-lock decision.
      state_d     = ST_SEARCH;
      slip_cnt_d  = 3'd0;
      wait_cnt_d  = 8'd0;
      good_cnt_d  = 10'd0;
      miss_cnt_d  = 4'd0;
      lock_lost_d = (state_q == ST_LOCKED);
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (good_word) begin
            good_cnt_d = 10'd1;
            if (LOCK_CNT == 10'd1) begin
              state_d     = ST_LOCKED;
              slip_cnt_d  = 3'd0;
              align_err_d = 1'b0;
              miss_cnt_d  = 4'd0;
            end else begin
              state_d = ST_VERIFY;
            end
          end else begin
            state_d = ST_SLIP;
          end
        end
        ST_SLIP: begin
          // Seven slips cover every rotation of a 7-bit word.
          if (slip_cnt_q == 3'd6) begin
            slip_cnt_d  = 3'd0;
            align_err_d = 1'b1;
          end else begin
            slip_cnt_d = slip_cnt_q + 3'd1;
          end
          wait_cnt_d = 8'd0;
          state_d    = ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            wait_cnt_d = 8'd0;
            state_d    = ST_SEARCH;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
        ST_VERIFY: begin
          if (good_word) begin
            good_cnt_d = good_cnt_q + 10'd1;
            if ((good_cnt_q + 10'd1) == LOCK_CNT) begin
              state_d     = ST_LOCKED;
              slip_cnt_d  = 3'd0;
              align_err_d = 1'b0;
              miss_cnt_d  = 4'd0;
            end
          end else begin
            good_cnt_d = 10'd0;
            state_d    = ST_SLIP;
          end
        end
        ST_LOCKED: begin
          if (good_word) begin
            miss_cnt_d = 4'd0;
          end else if ((miss_cnt_q + 4'd1) == LOSS_CNT) begin
            state_d     = ST_SEARCH;
            miss_cnt_d  = 4'd0;
            good_cnt_d  = 10'd0;
            lock_lost_d = 1'b1;
          end else begin
            miss_cnt_d = miss_cnt_q + 4'd1;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    // Outputs are registered from the next state so that they line up with
    // the state they describe.
    bitslip_d    = (state_d == ST_SLIP);
    locked_d     = (state_d == ST_LOCKED);
    word_valid_d = locked_d && good_word;
    word_data_d  = I_phase_align_pdata;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q      <= ST_SEARCH;
      slip_cnt_q   <= 3'd0;
      wait_cnt_q   <= 8'd0;
      good_cnt_q   <= 10'd0;
      miss_cnt_q   <= 4'd0;
      bitslip_q    <= 1'b0;
      locked_q     <= 1'b0;
      lock_lost_q  <= 1'b0;
      align_err_q  <= 1'b0;
      word_data_q  <= 7'd0;
      word_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slip_cnt_q   <= slip_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      good_cnt_q   <= good_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      bitslip_q    <= bitslip_d;
      locked_q     <= locked_d;
      lock_lost_q  <= lock_lost_d;
      align_err_q  <= align_err_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
    end
  end

`ifdef LVDS_ALIGN_SLIP_STATS_EN
  logic [7:0] slip_total_q, slip_total_d;

  // Counts pulses as they leave the block; only I_rst clears it.
  always_comb begin
    slip_total_d = slip_total_q;
    if (bitslip_q && (slip_total_q != 8'hFF)) begin
      slip_total_d = slip_total_q + 8'd1;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      slip_total_q <= 8'd0;
    end else begin
      slip_total_q <= slip_total_d;
    end
  end

  assign O_slip_total = slip_total_q;
`endif

  assign O_bitslip    = bitslip_q;
  assign O_locked     = locked_q;
  assign O_lock_lost  = lock_lost_q;
  assign O_align_err  = align_err_q;
  assign O_word_data  = word_data_q;
  assign O_word_valid = word_valid_q;
  assign O_dbg_state  = state_q;

endmodule

// File: tb/tb_lvds_word_align_ctrl.sv
// Testbench for lvds_word_align_ctrl (default parameters).
// The reference model tracks the link as "hunting", "blind after a slip"
// or "locked", with a run length of good words and a run of misses.
module tb_lvds_word_align_ctrl;

  localparam logic [6:0] PAT = 7'b1100011;
  localparam logic [6:0] ROT = 7'b0011110;
  localparam int SLIP_WAIT   = 15;
  localparam int LOCK_COUNT  = 64;
  localparam int LOSS_THRESH = 4;
  localparam int PERIOD      = SLIP_WAIT + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [6:0] pdata = 7'd0;
  logic       match = 1'b0;
  logic       realign = 1'b0;
  logic       O_bitslip, O_locked, O_lock_lost, O_align_err, O_word_valid;
  logic [6:0] O_word_data;
  logic [2:0] O_dbg_state;
  logic [7:0] dut_total;

`ifdef LVDS_ALIGN_SLIP_STATS_EN
  logic [7:0] O_slip_total;
  assign dut_total = O_slip_total;
`else
  assign dut_total = 8'd0;
`endif

  lvds_word_align_ctrl dut (
    .I_clk               (clk),
    .I_rst               (rst),
    .I_phase_align_pdata (pdata),
    .I_lane_match        (match),
    .I_realign           (realign),
    .O_bitslip           (O_bitslip),
    .O_locked            (O_locked),
    .O_lock_lost         (O_lock_lost),
    .O_align_err         (O_align_err),
    .O_word_data         (O_word_data),
    .O_word_valid        (O_word_valid),
    .O_dbg_state         (O_dbg_state)
`ifdef LVDS_ALIGN_SLIP_STATS_EN
    ,
    .O_slip_total        (O_slip_total)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model / scoreboard ----------------
  logic [19:0] exp_q[$];
  logic [19:0] exp_v, got_v;
  bit m_locked, m_err;
  int m_run, m_miss, m_blind, m_slips, m_total;

  task automatic model_step(input logic [6:0] p, input logic m, input logic ra, input logic r);
    bit good, slip_now, lost;
    logic [7:0] tot;
    good = m && (p == PAT);
    slip_now = 0;
    lost = 0;
    if (r) begin
      m_locked = 0; m_err = 0; m_run = 0; m_miss = 0;
      m_blind = 0; m_slips = 0; m_total = 0;
    end else if (m_blind > 0) begin
      // First blind cycle is the one in which the slip pulse is out.
      if (m_blind == SLIP_WAIT + 1) begin
        m_slips++;
        if (m_slips == 7) begin m_slips = 0; m_err = 1; end
        if (m_total < 255) m_total++;
      end
      m_blind--;
    end else if (ra) begin
      lost = m_locked;
      m_locked = 0; m_run = 0; m_miss = 0; m_slips = 0;
    end else if (m_locked) begin
      if (good) m_miss = 0;
      else begin
        m_miss++;
        if (m_miss == LOSS_THRESH) begin
          m_locked = 0; lost = 1; m_miss = 0; m_run = 0;
        end
      end
    end else begin
      if (good) begin
        m_run++;
        if (m_run == LOCK_COUNT) begin
          m_locked = 1; m_slips = 0; m_err = 0; m_miss = 0;
        end
      end else begin
        m_run = 0;
        slip_now = 1;
        m_blind = SLIP_WAIT + 1;
      end
    end
`ifdef LVDS_ALIGN_SLIP_STATS_EN
    tot = 8'(m_total);
`else
    tot = 8'd0;
`endif
    if (r) exp_q.push_back(20'd0);
    else exp_q.push_back({tot, slip_now, m_locked, lost, m_err, m_locked && good, p});
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input logic [6:0] p, input logic m, input logic ra, input logic r);
    pdata = p; match = m; realign = ra; rst = r;
    model_step(p, m, ra, r);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] got_vec();
    return {dut_total, O_bitslip, O_locked, O_lock_lost, O_align_err, O_word_valid, O_word_data};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      exp_v = exp_q.pop_front(); got_v = got_vec(); vectors++;
      if (got_v !== exp_v) begin
        miscompares++; $display("FAIL reset cyc %0d: got %h exp %h", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_good_lock();
    int first_lock = -1;
    int nslip = 0;
    cyc(PAT, 1, 0, 1); void'(exp_q.pop_front());
    for (int i = 1; i <= 80; i++) begin
      cyc(PAT, 1, 0, 0);
      exp_v = exp_q.pop_front(); got_v = got_vec(); vectors++;
      if (got_v !== exp_v) begin
        miscompares++; $display("FAIL good_lock cyc %0d: got %h exp %h", i, got_v, exp_v);
      end
      if (O_bitslip) nslip++;
      if (first_lock < 0 && O_locked) begin
        first_lock = i;
        vectors++;
        if (O_word_valid !== 1'b1) begin
          miscompares++; $display("FAIL good_lock_valid: got %b exp 1", O_word_valid);
        end
      end
    end
    vectors++;
    if (nslip != 0) begin miscompares++; $display("FAIL good_lock_slips: got %0d exp 0", nslip); end
    vectors++;
    if (first_lock != LOCK_COUNT) begin
      miscompares++; $display("FAIL good_lock_cycle: got %0d exp %0d", first_lock, LOCK_COUNT);
    end
  endtask

  task automatic test_rotated();
    int pulse_at[3];
    int pulses = 0;
    int first_lock = -1;
    cyc(PAT, 1, 0, 1); void'(exp_q.pop_front());
    for (int i = 1; i <= 200 && first_lock < 0; i++) begin
      cyc((pulses < 3) ? ROT : PAT, 1, 0, 0);
      exp_v = exp_q.pop_front(); got_v = got_vec(); vectors++;
      if (got_v !== exp_v) begin
        miscompares++; $display("FAIL rotated cyc %0d: got %h exp %h", i, got_v, exp_v);
      end
      if (O_bitslip) begin
        if (pulses < 3) pulse_at[pulses] = i;
        pulses++;
      end
      if (O_locked) first_lock = i;
    end
    vectors++;
    if (pulses != 3) begin miscompares++; $display("FAIL rotated_pulses: got %0d exp 3", pulses); end
    else begin
      for (int k = 1; k < 3; k++) begin
        vectors++;
        if (pulse_at[k] - pulse_at[k-1] != PERIOD) begin
          miscompares++;
          $display("FAIL rotated_spacing %0d: got %0d exp %0d", k, pulse_at[k] - pulse_at[k-1], PERIOD);
        end
      end
      vectors++;
      if (first_lock != pulse_at[2] + 1 + SLIP_WAIT + LOCK_COUNT) begin
        miscompares++;
        $display("FAIL rotated_lock: got %0d exp %0d", first_lock, pulse_at[2] + 1 + SLIP_WAIT + LOCK_COUNT);
      end
    end
  endtask

  task automatic test_never_match();
    int pulses = 0, last = -1, bad_space = 0, p7 = -1, err_at = -1, lock_seen = 0;
    cyc(PAT, 1, 0, 1); void'(exp_q.pop_front());
    for (int i = 1; i <= 9 * PERIOD; i++) begin
      cyc(7'h00, 1'($urandom_range(0, 1)), 0, 0);
      exp_v = exp_q.pop_front(); got_v = got_vec(); vectors++;
      if (got_v !== exp_v) begin
        miscompares++; $display("FAIL never_match cyc %0d: got %h exp %h", i, got_v, exp_v);
      end
      if (O_bitslip) begin
        pulses++;
        if (last >= 0 && i - last != PERIOD) bad_space++;
        last = i;
        if (pulses == 7) p7 = i;
      end
      if (err_at < 0 && O_align_err) err_at = i;
      if (O_locked) lock_seen++;
    end
    vectors++;
    if (p7 < 0 || err_at != p7 + 1) begin
      miscompares++; $display("FAIL never_match_err: got %0d exp %0d", err_at, p7 + 1);
    end
    vectors++;
    if (bad_space != 0) begin miscompares++; $display("FAIL never_match_spacing: got %0d bad exp 0", bad_space); end
    vectors++;
    if (lock_seen != 0) begin miscompares++; $display("FAIL never_match_lock: got %0d exp 0", lock_seen); end
  endtask

  // Brings the link to lock with good words; a missing lock counts as a miscompare.
  task automatic get_locked(input string tag);
    int ok = 0;
    cyc(PAT, 1, 0, 1); void'(exp_q.pop_front());
    for (int i = 1; i <= 100 && !ok; i++) begin
      cyc(PAT, 1, 0, 0);
      exp_v = exp_q.pop_front(); got_v = got_vec(); vectors++;
      if (got_v !== exp_v) begin
        miscompares++; $display("FAIL %s lock cyc %0d: got %h exp %h", tag, i, got_v, exp_v);
      end
      if (O_locked) ok = 1;
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL %s lock_timeout: got 0 exp 1", tag); end
  endtask

  task automatic test_loss();
    logic [6:0] seq_p[8] = '{ROT, ROT, ROT, PAT, ROT, ROT, ROT, ROT};
    int lost_cnt = 0;
    get_locked("loss");
    for (int i = 0; i < 8; i++) begin
      cyc(seq_p[i], 1, 0, 0);
      exp_v = exp_q.pop_front(); got_v = got_vec(); vectors++;
      if (got_v !== exp_v) begin
        miscompares++; $display("FAIL loss cyc %0d: got %h exp %h", i, got_v, exp_v);
      end
      if (O_lock_lost) lost_cnt++;
      if (i < 7) begin
        vectors++;
        if (O_locked !== 1'b1) begin miscompares++; $display("FAIL loss_held %0d: got %b exp 1", i, O_locked); end
      end
    end
    vectors++;
    if (O_lock_lost !== 1'b1 || O_locked !== 1'b0) begin
      miscompares++; $display("FAIL loss_drop: got lost=%b locked=%b exp lost=1 locked=0", O_lock_lost, O_locked);
    end
    // Back in SEARCH: a bad word must produce a slip straight away.
    cyc(ROT, 1, 0, 0);
    exp_v = exp_q.pop_front(); got_v = got_vec(); vectors++;
    if (got_v !== exp_v) begin
      miscompares++; $display("FAIL loss_search: got %h exp %h", got_v, exp_v);
    end
    if (O_lock_lost) lost_cnt++;
    vectors++;
    if (O_bitslip !== 1'b1 || lost_cnt != 1) begin
      miscompares++; $display("FAIL loss_after: got slip=%b lost_cnt=%0d exp slip=1 lost_cnt=1", O_bitslip, lost_cnt);
    end
  endtask

  task automatic test_realign_loss();
    int lost_cnt = 0, relock = -1;
    get_locked("realign");
    for (int i = 0; i < 4; i++) begin
      cyc(ROT, 1, (i == 3), 0);
      exp_v = exp_q.pop_front(); got_v = got_vec(); vectors++;
      if (got_v !== exp_v) begin
        miscompares++; $display("FAIL realign cyc %0d: got %h exp %h", i, got_v, exp_v);
      end
      if (O_lock_lost) lost_cnt++;
    end
    vectors++;
    if (O_lock_lost !== 1'b1 || O_locked !== 1'b0) begin
      miscompares++; $display("FAIL realign_drop: got lost=%b locked=%b exp lost=1 locked=0", O_lock_lost, O_locked);
    end
    for (int i = 1; i <= 100 && relock < 0; i++) begin
      cyc(PAT, 1, 0, 0);
      exp_v = exp_q.pop_front(); got_v = got_vec(); vectors++;
      if (got_v !== exp_v) begin
        miscompares++; $display("FAIL realign relock cyc %0d: got %h exp %h", i, got_v, exp_v);
      end
      if (O_lock_lost) lost_cnt++;
      if (O_locked) relock = i;
    end
    vectors++;
    if (lost_cnt != 1 || relock != LOCK_COUNT) begin
      miscompares++; $display("FAIL realign_relock: got lost_cnt=%0d relock=%0d exp 1 %0d", lost_cnt, relock, LOCK_COUNT);
    end
  endtask

  task automatic test_slip_reset();
    int extra = 0;
    cyc(PAT, 1, 0, 1); void'(exp_q.pop_front());
    cyc(ROT, 1, 0, 0);
    exp_v = exp_q.pop_front(); got_v = got_vec(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL slip_reset pulse: got %h exp %h", got_v, exp_v); end
    cyc(ROT, 1, 0, 1);
    exp_v = exp_q.pop_front(); got_v = got_vec(); vectors++;
    if (got_v !== exp_v) begin miscompares++; $display("FAIL slip_reset rst: got %h exp %h", got_v, exp_v); end
    for (int i = 0; i < 2 * PERIOD; i++) begin
      cyc(PAT, 1, 0, 0);
      exp_v = exp_q.pop_front(); got_v = got_vec(); vectors++;
      if (got_v !== exp_v) begin
        miscompares++; $display("FAIL slip_reset cyc %0d: got %h exp %h", i, got_v, exp_v);
      end
      if (O_bitslip) extra++;
    end
    vectors++;
    if (extra != 0) begin miscompares++; $display("FAIL slip_reset_extra: got %0d exp 0", extra); end
  endtask

  task automatic test_random();
    int prob_tab[4] = '{100, 97, 50, 0};
    int prob, len, n = 0;
    logic [6:0] p;
    logic m;
    cyc(PAT, 1, 0, 1); void'(exp_q.pop_front());
    while (n < 3000) begin
      prob = prob_tab[$urandom_range(0, 3)];
      len = $urandom_range(20, 150);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 99) < prob) begin p = PAT; m = 1'b1; end
        else begin p = 7'($urandom_range(0, 127)); m = 1'($urandom_range(0, 1)); end
        cyc(p, m, ($urandom_range(0, 199) == 0), 1'b0);
        exp_v = exp_q.pop_front(); got_v = got_vec(); vectors++;
        if (got_v !== exp_v) begin
          miscompares++; $display("FAIL random cyc %0d: got %h exp %h", n, got_v, exp_v);
        end
        n++;
      end
    end
  endtask

`ifdef LVDS_ALIGN_SLIP_STATS_EN
  task automatic test_stats();
    cyc(PAT, 1, 0, 1); void'(exp_q.pop_front());
    for (int i = 0; i < 300 * PERIOD + 4; i++) begin
      cyc(7'h00, 1, 0, 0);
      exp_v = exp_q.pop_front(); got_v = got_vec(); vectors++;
      if (got_v !== exp_v) begin
        miscompares++; $display("FAIL stats cyc %0d: got %h exp %h", i, got_v, exp_v);
      end
    end
    vectors++;
    if (O_slip_total !== 8'd255) begin miscompares++; $display("FAIL stats_sat: got %0d exp 255", O_slip_total); end
    for (int i = 0; i < PERIOD; i++) cyc(PAT, 1, 1, 0);
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    vectors++;
    if (O_slip_total !== 8'd255) begin miscompares++; $display("FAIL stats_realign: got %0d exp 255", O_slip_total); end
    cyc(PAT, 1, 0, 1); void'(exp_q.pop_front());
    vectors++;
    if (O_slip_total !== 8'd0) begin miscompares++; $display("FAIL stats_rst: got %0d exp 0", O_slip_total); end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_good_lock();
    test_rotated();
    test_never_match();
    test_loss();
    test_realign_loss();
    test_slip_reset();
    test_random();
`ifdef LVDS_ALIGN_SLIP_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
